// File: rtl/hazard_sequencer_pkg.sv
// Shared pipeline-control definitions: state encodings, PC select codes and
// the control-bundle payload driven by the hazard sequencer.
package hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam logic PC_SEQ    = 1'b0;
    localparam logic PC_TARGET = 1'b1;

    typedef struct packed {
        logic pc_write;
        logic pc_sel;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_hold;
    } ctrl_t;

    // Normal flow: fetch advances, nothing squashed.
    localparam ctrl_t CTRL_DEFAULT = '{
        pc_write: 1'b1, pc_sel: PC_SEQ, if_id_write: 1'b1,
        if_id_flush: 1'b0, id_ex_bubble: 1'b0, pipe_hold: 1'b0
    };

    // Data memory not ready: whole pipe frozen in place.
    localparam ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, pc_sel: PC_SEQ, if_id_write: 1'b0,
        if_id_flush: 1'b0, id_ex_bubble: 1'b0, pipe_hold: 1'b1
    };

    // Fatal timeout: frozen with the fetch slot squashed.
    localparam ctrl_t CTRL_HALT = '{
        pc_write: 1'b0, pc_sel: PC_SEQ, if_id_write: 1'b0,
        if_id_flush: 1'b1, id_ex_bubble: 1'b0, pipe_hold: 1'b1
    };

    // Reset asserted: keep PC, fill IF/ID and ID/EX with NOPs.
    localparam ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, pc_sel: PC_SEQ, if_id_write: 1'b0,
        if_id_flush: 1'b1, id_ex_bubble: 1'b1, pipe_hold: 1'b0
    };

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module hazard_sequencer_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up to all-ones and stick there until cleared.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Central pipeline-control sequencer: arbitrates memory stalls, load-use
// bubbles and control-hazard flushes, with a memory-timeout halt and
// saturating stall/flush performance counters. Controls are Mealy outputs.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             load_use,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned RW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          ret_q, ret_d;
    logic          halted_q, halted_d;
    ctrl_t         ctrl;
    logic          stall_inc;
    logic          flush_inc;
    logic          in_flush;

    // A not-busy cycle in MEM_WAIT entered from FLUSH resumes flush behaviour.
    assign in_flush = (state_q == ST_FLUSH) || ((state_q == ST_MEM_WAIT) && ret_q);

    // Next-state, control outputs and counter increments.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wait_d    = wait_q;
        ret_d     = ret_q;
        halted_d  = halted_q;
        ctrl      = CTRL_DEFAULT;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        if (state_q == ST_HALT) begin
            ctrl = CTRL_HALT;
        end else if (mem_busy) begin
            ctrl      = CTRL_FREEZE;
            stall_inc = 1'b1;
            if (state_q == ST_MEM_WAIT) begin
                wait_d = wait_q + WW'(1);
            end else begin
                wait_d = WW'(1);
                ret_d  = (state_q == ST_FLUSH);
            end
            if (wait_d >= WW'(MEM_TIMEOUT)) begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
            end else begin
                state_d = ST_MEM_WAIT;
            end
        end else if (in_flush) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.pc_sel      = PC_SEQ;
            wait_d           = '0;
            ret_d            = 1'b0;
            if (rem_q > RW'(1)) begin
                rem_d   = rem_q - RW'(1);
                state_d = ST_FLUSH;
            end else begin
                rem_d   = '0;
                state_d = ST_RUN;
            end
        end else begin
            wait_d  = '0;
            ret_d   = 1'b0;
            state_d = ST_RUN;
            if (load_use) begin
                // Kill is dropped here; the branch re-resolves next cycle.
                ctrl.pc_write     = 1'b0;
                ctrl.if_id_write  = 1'b0;
                ctrl.id_ex_bubble = 1'b1;
                stall_inc         = 1'b1;
            end else if (kill) begin
                ctrl.pc_sel      = PC_TARGET;
                ctrl.if_id_flush = 1'b1;
                flush_inc        = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    rem_d   = RW'(FLUSH_CYCLES - 1);
                end
            end
        end

        if (reset) begin
            ctrl      = CTRL_RESET;
            stall_inc = 1'b0;
            flush_inc = 1'b0;
        end
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            rem_q    <= '0;
            wait_q   <= '0;
            ret_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            wait_q   <= wait_d;
            ret_q    <= ret_d;
            halted_q <= halted_d;
        end
    end

    hazard_sequencer_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    hazard_sequencer_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .clr   (cnt_clr),
        .count (flush_cnt)
    );

    assign pc_write     = ctrl.pc_write;
    assign pc_sel       = ctrl.pc_sel;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign pipe_hold    = ctrl.pipe_hold;
    assign halted       = halted_q;
    assign state        = state_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (FLUSH_CYCLES=3, MEM_TIMEOUT=64, CNT_W=4).
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       kill;
    logic       load_use;
    logic       mem_busy;
    logic       cnt_clr;
    logic       pc_write;
    logic       pc_sel;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       pipe_hold;
    logic       halted;
    logic [1:0] state;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_sequencer #(
        .FLUSH_CYCLES (3),
        .MEM_TIMEOUT  (64),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .kill         (kill),
        .load_use     (load_use),
        .mem_busy     (mem_busy),
        .cnt_clr      (cnt_clr),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .pipe_hold    (pipe_hold),
        .halted       (halted),
        .state        (state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; kill = 1'b0; load_use = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;

        // Two reset cycles with forced outputs
        sample();
        chk("rst0_pc_write", pc_write, 0);
        chk("rst0_if_id_flush", if_id_flush, 1);
        chk("rst0_id_ex_bubble", id_ex_bubble, 1);
        next_cycle();
        sample();
        chk("rst1_pc_write", pc_write, 0);
        chk("rst1_if_id_write", if_id_write, 0);
        chk("rst1_pipe_hold", pipe_hold, 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // First idle cycle after reset
        sample();
        chk("idle_state", state, 0);
        chk("idle_pc_write", pc_write, 1);
        chk("idle_if_id_write", if_id_write, 1);
        chk("idle_stall", stall_cnt, 0);
        chk("idle_flush", flush_cnt, 0);
        chk("idle_halted", halted, 0);
        next_cycle();

        // Taken kill with three flush slots; a second kill inside FLUSH is ignored
        kill = 1'b1;
        sample();
        chk("kill_pc_sel", pc_sel, 1);
        chk("kill_if_id_flush", if_id_flush, 1);
        next_cycle();
        sample();
        chk("fl1_state", state, 2);
        chk("fl1_pc_sel", pc_sel, 0);
        chk("fl1_if_id_flush", if_id_flush, 1);
        chk("fl1_flush_cnt", flush_cnt, 1);
        next_cycle();
        kill = 1'b0;
        sample();
        chk("fl2_state", state, 2);
        chk("fl2_if_id_flush", if_id_flush, 1);
        next_cycle();
        sample();
        chk("fl_done_state", state, 0);
        chk("fl_done_flush_cnt", flush_cnt, 1);
        chk("fl_done_if_id_flush", if_id_flush, 0);
        next_cycle();

        // load_use beats kill in the same cycle
        load_use = 1'b1; kill = 1'b1;
        sample();
        chk("lu_pc_write", pc_write, 0);
        chk("lu_id_ex_bubble", id_ex_bubble, 1);
        chk("lu_pc_sel", pc_sel, 0);
        next_cycle();
        load_use = 1'b0;
        sample();
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_flush_cnt", flush_cnt, 1);
        chk("lu_kill_pc_sel", pc_sel, 1);
        next_cycle();
        kill = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        chk("lu_back_run", state, 0);
        chk("lu_flush_cnt2", flush_cnt, 2);

        // Clear counters
        next_cycle();
        cnt_clr = 1'b1;
        next_cycle();
        cnt_clr = 1'b0;
        sample();
        chk("clr_stall", stall_cnt, 0);
        chk("clr_flush", flush_cnt, 0);
        next_cycle();

        // Memory busy for five cycles, then release with a kill
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("mb_pipe_hold", pipe_hold, 1);
            chk("mb_pc_write", pc_write, 0);
            chk("mb_state", state, (i == 0) ? 0 : 1);
            next_cycle();
        end
        mem_busy = 1'b0; kill = 1'b1;
        sample();
        chk("mb_rel_state", state, 1);
        chk("mb_rel_pc_sel", pc_sel, 1);
        chk("mb_rel_pipe_hold", pipe_hold, 0);
        chk("mb_stall_cnt", stall_cnt, 5);
        next_cycle();
        kill = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        chk("mb_flush_cnt", flush_cnt, 1);
        chk("mb_back_run", state, 0);
        next_cycle();

        // Memory busy for 64 cycles hits the timeout
        mem_busy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) begin
                sample();
                chk("to_last_state", state, 1);
                chk("to_last_halted", halted, 0);
            end
            next_cycle();
        end
        sample();
        chk("to_halted", halted, 1);
        chk("to_state", state, 3);
        chk("to_pc_write", pc_write, 0);
        chk("to_if_id_write", if_id_write, 0);
        chk("to_pipe_hold", pipe_hold, 1);
        chk("to_stall_sat", stall_cnt, 15);
        next_cycle();
        mem_busy = 1'b0; kill = 1'b1;
        next_cycle();
        kill = 1'b0;
        sample();
        chk("halt_sticky_state", state, 3);
        chk("halt_flush_frozen", flush_cnt, 1);
        next_cycle();

        // One reset cycle leaves HALT
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        sample();
        chk("rst_halt_state", state, 0);
        chk("rst_halt_halted", halted, 0);
        chk("rst_halt_stall", stall_cnt, 0);
        next_cycle();

        // Memory stall inside FLUSH resumes flushing afterwards
        kill = 1'b1;
        next_cycle();
        kill = 1'b0; mem_busy = 1'b1;
        sample();
        chk("fm_state", state, 2);
        chk("fm_pipe_hold", pipe_hold, 1);
        next_cycle();
        sample();
        chk("fm_wait_state", state, 1);
        next_cycle();
        mem_busy = 1'b0; kill = 1'b1;
        sample();
        chk("fm_rel_pc_sel", pc_sel, 0);
        chk("fm_rel_if_id_flush", if_id_flush, 1);
        next_cycle();
        kill = 1'b0;
        sample();
        chk("fm_ret_state", state, 2);
        chk("fm_flush_cnt", flush_cnt, 1);
        next_cycle();
        next_cycle();

        // Stall counter saturates, then clear beats a same-cycle increment
        load_use = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
        end
        sample();
        chk("sat_stall", stall_cnt, 15);
        cnt_clr = 1'b1;
        next_cycle();
        cnt_clr = 1'b0; load_use = 1'b0;
        sample();
        chk("clr_lu_stall", stall_cnt, 0);
        chk("clr_lu_flush", flush_cnt, 0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central pipeline-control sequencer for the 16-bit pipelined processor.
- Takes the branch/jump kill from the ID-stage control-hazard logic, the load-use detect, and the data-memory busy flag.
- Drives PC write/select, IF/ID write/flush, ID/EX bubble and a global hold.
- Runs a multi-cycle flush/wait/halt state machine and keeps saturating performance counters.

Parameters:
- FLUSH_CYCLES, 1, bubbles inserted per taken kill (≥1); cycles beyond the first spent in FLUSH.
- MEM_TIMEOUT, 64, max consecutive mem_busy cycles before fatal halt (≥1).
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- kill  in  1  taken branch/jump/call/ret/loop in ID (control-hazard output)
- load_use  in  1  ID instruction needs result of load now in EX
- mem_busy  in  1  data memory not ready this cycle
- cnt_clr  in  1  synchronous clear of both counters
- pc_write  out  1  PC register enable
- pc_sel  out  1  0 = sequential PC+1, 1 = branch/jump target
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- halted  out  1  sticky fatal timeout
- state  out  2  current state (debug)
- stall_cnt  out  CNT_W  load-use stall cycles + mem-wait cycles, saturating
- flush_cnt  out  CNT_W  taken kills, saturating

Behaviour:
- States: RUN = 0, MEM_WAIT = 1, FLUSH = 2, HALT = 3. State is registered; outputs are combinational from state and inputs (Mealy).
- Defaults, unless overridden below: pc_write = 1, pc_sel = 0, if_id_write = 1, all other controls 0.
- Input priority, every state except HALT: mem_busy > load_use > kill.
- RUN:
  - mem_busy: pc_write = 0, if_id_write = 0, pipe_hold = 1; next MEM_WAIT; wait counter = 1; stall_cnt + 1.
  - Else load_use: pc_write = 0, if_id_write = 0, id_ex_bubble = 1; stay RUN; stall_cnt + 1. A kill in the same cycle is ignored; the branch re-evaluates next cycle with forwarded operands.
  - Else kill: pc_sel = 1, if_id_flush = 1; flush_cnt + 1. Next is FLUSH with remaining = FLUSH_CYCLES - 1 if FLUSH_CYCLES > 1, else RUN.
- MEM_WAIT:
  - mem_busy: same outputs as the RUN mem_busy case; wait counter + 1; stall_cnt + 1.
  - If the wait counter reaches MEM_TIMEOUT while mem_busy is still 1: next HALT, halted set.
  - mem_busy = 0: apply the RUN rules this cycle (load_use/kill evaluated); next state per those rules.
- FLUSH:
  - pc_sel = 0, if_id_flush = 1; kill and load_use ignored (the ID instruction is a flushed slot).
  - remaining decrements each cycle; RUN when it reaches 0.
  - mem_busy in FLUSH: freeze as in MEM_WAIT; remaining held; wait counter runs; timeout applies. Return to FLUSH when not busy — a separate return flag is kept.
- HALT: pc_write = 0, if_id_write = 0, pipe_hold = 1, if_id_flush = 1; exit only by reset.
- Counters:
  - Saturate at all-ones (no wrap).
  - cnt_clr zeroes both counters and takes priority over an increment in the same cycle.
  - Counters are frozen in HALT.
- Reset, including mid-FLUSH, MEM_WAIT or HALT:
  - Next state RUN; counters, wait counter, remaining, return flag and halted all 0.
  - While reset = 1, outputs are forced to: pc_write = 0, if_id_write = 0, if_id_flush = 1, id_ex_bubble = 1, pipe_hold = 0, pc_sel = 0.

Decomposition:
- Shared include pipe_ctrl_defs.v, alongside opcodes.v: state encodings ST_RUN / ST_MEM_WAIT / ST_FLUSH / ST_HALT and PC_SEQ / PC_TARGET.
- One sub-module, sat_counter (parameter W; inputs inc and clr; saturating), instantiated twice.

Test Plan:
- Reset for 2 cycles, then idle: during reset pc_write = 0, if_id_flush = 1, id_ex_bubble = 1. First cycle after reset: state = 0, pc_write = 1, counters 0.
- kill = 1 for one cycle with FLUSH_CYCLES = 3: that cycle pc_sel = 1, if_id_flush = 1. Next 2 cycles state = 2, pc_sel = 0, if_id_flush = 1; a kill pulse there is ignored. Then RUN; flush_cnt = 1.
- load_use = 1 and kill = 1 together: pc_write = 0, id_ex_bubble = 1, pc_sel = 0, flush_cnt unchanged, stall_cnt = 1. Next cycle kill alone gives pc_sel = 1.
- mem_busy high 5 cycles with MEM_TIMEOUT = 64: pipe_hold = 1 for 5 cycles, state = 1 from cycle 2, stall_cnt = 5. The cycle mem_busy drops with kill = 1 gives pc_sel = 1.
- mem_busy held 64 cycles with MEM_TIMEOUT = 64: halted = 1, state = 3, all writes 0. Then reset = 1 for one cycle gives state = 0, halted = 0.
- CNT_W = 4, 20 load_use cycles: stall_cnt saturates at 15. cnt_clr together with load_use gives stall_cnt = 0.
